// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory, decode and branch resolution.
// master = fetch unit side, slave = the environment around it.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order requests to imem, prefetch FIFO toward decode,
// redirect flush with a drop counter that discards stale in-flight responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      pc;
  logic [31:0]      rsp_pc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic        credit_ok;
  logic        req_fire;
  logic        rsp_fire;
  logic        push;
  logic        pop;
  logic [31:0] target_pc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Outstanding requests and buffered entries share one pool of DEPTH slots, so the FIFO never overflows.
  assign credit_ok = ((CNT_W+1)'(outstanding) + (CNT_W+1)'(count)) < (CNT_W+1)'(DEPTH);

  assign bus.imem_req_valid = !reset && !bus.redirect_valid && credit_ok;
  assign bus.imem_req_addr  = pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // A response with nothing outstanding is a leftover from before reset.
  assign rsp_fire  = bus.imem_rsp_valid && (outstanding != '0);
  assign push      = rsp_fire && (drop_cnt == '0) && !bus.redirect_valid;

  assign bus.if_valid = (count != '0) && !bus.redirect_valid;
  assign bus.if_pc    = (count != '0) ? pc_mem[rd_ptr]    : '0;
  assign bus.if_instr = (count != '0) ? instr_mem[rd_ptr] : '0;
  assign pop          = bus.if_valid && bus.if_ready;

  assign target_pc = bus.redirect_pc & ~32'h3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
      if (bus.redirect_valid) begin
        pc       <= target_pc;
        rsp_pc   <= target_pc;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        // Everything still in flight after this edge belongs to the old stream.
        drop_cnt <= outstanding - CNT_W'(rsp_fire);
      end else begin
        if (req_fire)
          pc <= pc + 32'd4;
        if (rsp_fire && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CNT_W'(1);
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= bus.imem_rsp_data;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decode stage.
- Owns the PC and issues in-order word fetches to a variable-latency instruction memory over a request/response handshake.
- Buffers returned instructions in a small prefetch FIFO and presents {pc, instr} pairs to decode over a valid/ready handshake.
- Accepts redirects (branch/jump target) that flush buffered state and discard stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset release
DEPTH, 4, prefetch FIFO entries; also the cap on (outstanding requests + buffered entries); legal 2..16
CNT_W, $clog2(DEPTH+1), width of the occupancy, outstanding and drop counters

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  response data valid (in request order, at least 1 cycle after acceptance)
imem_rsp_data  input  32  instruction word
if_valid  output  1  {if_pc, if_instr} valid toward decode
if_ready  input  1  decode consumes the head entry
if_pc  output  32  PC of head entry
if_instr  output  32  instruction of head entry
redirect_valid  input  1  redirect request from branch resolution
redirect_pc  input  32  new fetch PC; bits [1:0] ignored (treated as 0)

Behaviour:
- Reset (async, active-high):
  - pc = RESET_PC and rsp_pc = RESET_PC.
  - FIFO count, outstanding and drop_cnt = 0.
  - imem_req_valid = 0, if_valid = 0.
  - if_pc and if_instr = 0 (FIFO storage is not required to clear).
- Reset mid-operation aborts all state. Responses arriving after reset release with outstanding = 0 are ignored.
- Request issue:
  - imem_req_valid = !redirect_valid && (outstanding + count < DEPTH), using registered values.
  - imem_req_addr = pc.
  - Accepted when imem_req_valid && imem_req_ready: pc += 4 (wraps modulo 2^32) and outstanding increments.
  - A request is held stable until accepted, except that it may be withdrawn in a redirect cycle.
- Response:
  - Each imem_rsp_valid cycle decrements outstanding.
  - If drop_cnt > 0: drop_cnt decrements and the data is discarded.
  - Otherwise {rsp_pc, data} is written at the FIFO tail and rsp_pc += 4.
  - Overflow cannot occur because of the credit rule.
  - imem_rsp_valid with outstanding = 0 is ignored with no state change.
- Output:
  - if_valid = (count != 0) && !redirect_valid.
  - if_pc and if_instr come from the head entry.
  - Pop when if_valid && if_ready.
  - Simultaneous push and pop in the same cycle leaves count unchanged.
  - Holding if_ready = 0 keeps the head stable.
- Redirect (redirect_valid = 1), with priority over everything else:
  - No request is issued and no pop occurs.
  - Next edge: FIFO flushed (count = 0, pointers = 0).
  - pc = {redirect_pc[31:2], 2'b00} and rsp_pc = the same value.
  - drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0); any response arriving in the redirect cycle is itself discarded.
  - Back-to-back redirects: the last one wins and the drop count is recomputed each cycle.
- Latency, with zero-wait memory (req_ready = 1, response 1 cycle after acceptance):
  - Request issued in cycle N; response in N+1; if_valid in N+2.
  - Steady state is 1 instruction/cycle when DEPTH ≥ 3.
  - First request at RESET_PC is in the first cycle after reset deassertion.
  - Redirect at cycle R: request to the target in R+1; if_valid for the target no earlier than R+3.
- Invariants:
  - outstanding ≤ DEPTH.
  - drop_cnt ≤ outstanding.
  - count + outstanding ≤ DEPTH.

Test Plan:
1. Zero-wait memory, mem[i] = 0x1000_0000+i, if_ready = 1, 10 cycles after reset → if_valid from cycle 2; if_pc sequence 0x0, 0x4, 0x8…; if_instr 0x1000_0000, 0x1000_0001…; one per cycle.
2. if_ready = 0 for 8 cycles → imem_req_valid drops after count + outstanding = 4; if_pc holds 0x0; when if_ready returns, entries 0x0, 0x4, 0x8, 0xC drain with no loss or duplication.
3. Memory latency 3 with 2 outstanding, redirect_valid with redirect_pc = 0x0000_0102 → both stale responses discarded; next if_pc = 0x0000_0100; its if_instr is mem[0x40].
4. Redirect in the same cycle as imem_rsp_valid with outstanding = 1 → that response is dropped; drop_cnt = 0; the target fetch appears at if_pc = target.
5. imem_req_ready toggling 1,0,0,1 → imem_req_addr is stable while stalled; PCs are consecutive with no skipped addresses.
6. Assert reset mid-stream with 2 outstanding and 2 buffered → if_valid = 0 immediately; after release, fetch restarts at RESET_PC; late responses arriving with outstanding = 0 are ignored.
